// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one serial divider between NUM_REQ requesters.
// Define DIVARB_ZERO_BYPASS_EN to answer divide-by-zero locally without using the divider.
module div_arbiter #(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic [NUM_REQ-1:0]               req_vld_i,
  output logic [NUM_REQ-1:0]               req_rdy_o,
  input  logic [NUM_REQ*TRANS_ID_BITS-1:0] req_id_i,
  input  logic [NUM_REQ*2-1:0]             req_opcode_i,
  input  logic [NUM_REQ*WIDTH-1:0]         req_op_a_i,
  input  logic [NUM_REQ*WIDTH-1:0]         req_op_b_i,
  output logic [NUM_REQ-1:0]               resp_vld_o,
  input  logic [NUM_REQ-1:0]               resp_rdy_i,
  output logic [TRANS_ID_BITS-1:0]         resp_id_o,
  output logic [WIDTH-1:0]                 resp_res_o,
  output logic                             div_in_vld_o,
  input  logic                             div_in_rdy_i,
  output logic [TRANS_ID_BITS-1:0]         div_id_o,
  output logic [1:0]                       div_opcode_o,
  output logic [WIDTH-1:0]                 div_op_a_o,
  output logic [WIDTH-1:0]                 div_op_b_o,
  output logic                             div_flush_o,
  input  logic                             div_out_vld_i,
  output logic                             div_out_rdy_o,
  input  logic [TRANS_ID_BITS-1:0]         div_id_i,
  input  logic [WIDTH-1:0]                 div_res_i,
  output logic                             busy_o
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned OPC_W = 2;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [OPC_W-1:0]         opcode;
    logic [WIDTH-1:0]         op_a;
    logic [WIDTH-1:0]         op_b;
  } op_t;

`ifdef DIVARB_ZERO_BYPASS_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, BYPASS = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_e;
`endif

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  op_t              op_q, op_d;

  op_t              req_ops [NUM_REQ];
  logic             grant_found;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] ptr_next;

  // Unpack the flat request buses into one payload per requester.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_ops[k] = {req_id_i[k*TRANS_ID_BITS +: TRANS_ID_BITS],
                         req_opcode_i[k*OPC_W +: OPC_W],
                         req_op_a_i[k*WIDTH +: WIDTH],
                         req_op_b_i[k*WIDTH +: WIDTH]};
  end

  // First valid requester at or after the pointer, wrapping.
  always_comb begin : rr_pick
    logic [31:0] cand;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(ptr_q) + i) % NUM_REQ;
      if (!grant_found && req_vld_i[cand[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
    ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_comb begin : fsm_comb
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    op_d          = op_q;
    req_rdy_o     = '0;
    resp_vld_o    = '0;
    resp_id_o     = '0;
    resp_res_o    = '0;
    div_in_vld_o  = 1'b0;
    div_out_rdy_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (!flush_i && div_in_rdy_i && grant_found) begin
          req_rdy_o[grant_idx] = 1'b1;
          op_d                 = req_ops[grant_idx];
          owner_d              = grant_idx;
          ptr_d                = ptr_next;
          state_d              = ISSUE;
`ifdef DIVARB_ZERO_BYPASS_EN
          if (req_ops[grant_idx].op_b == '0) state_d = BYPASS;
`endif
        end
      end
      ISSUE: begin
        div_in_vld_o = !flush_i;
        state_d      = WAIT;
      end
      WAIT: begin
        resp_id_o  = div_id_i;
        resp_res_o = div_res_i;
        if (!flush_i) begin
          resp_vld_o[owner_q] = div_out_vld_i;
          div_out_rdy_o       = resp_rdy_i[owner_q];
          if (div_out_vld_i && resp_rdy_i[owner_q]) state_d = IDLE;
        end
      end
`ifdef DIVARB_ZERO_BYPASS_EN
      BYPASS: begin
        // Divide-by-zero: quotient is all ones, remainder is the dividend.
        resp_id_o  = op_q.id;
        resp_res_o = op_q.opcode[1] ? op_q.op_a : {WIDTH{1'b1}};
        if (!flush_i) begin
          resp_vld_o[owner_q] = 1'b1;
          if (resp_rdy_i[owner_q]) state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d = IDLE;
      owner_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin : state_reg
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op_q    <= op_d;
    end
  end

  assign div_id_o     = op_q.id;
  assign div_opcode_o = op_q.opcode;
  assign div_op_a_o   = op_q.op_a;
  assign div_op_b_o   = op_q.op_b;
  assign div_flush_o  = flush_i;
  assign busy_o       = (state_q != IDLE);

`ifndef SYNTHESIS
  // The divider must hand back the id it was issued; the result is forwarded regardless.
  always_ff @(posedge clk_i) begin : id_guard
    if (rst_ni && state_q == WAIT && div_out_vld_i && !flush_i) begin
      id_match: assert (div_id_i == op_q.id)
        else $error("div_arbiter: divider returned id %0d, issued id %0d", div_id_i, op_q.id);
    end
  end
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: directed scenarios plus random traffic against a
// behavioural divider and a transaction-level reference model.
module tb_div_arbiter;

  localparam int N = 3;
  localparam int W = 64;
  localparam int T = 3;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
`ifdef DIVARB_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b1;
  logic [N-1:0] req_vld = '0, req_rdy, resp_vld, resp_rdy = '0;
  logic [N*T-1:0] req_id;
  logic [N*2-1:0] req_opc;
  logic [N*W-1:0] req_a, req_b;
  logic [T-1:0] resp_id, div_id_o, div_id_in;
  logic [W-1:0] resp_res, div_a, div_b, div_res_in;
  logic [1:0] div_opc;
  logic div_in_vld, div_in_rdy, div_flush, div_out_vld, div_out_rdy, busy;

  logic [T-1:0] r_id [N];
  logic [1:0]   r_opc [N];
  logic [W-1:0] r_a [N];
  logic [W-1:0] r_b [N];

  int n_chk = 0;
  int n_bad = 0;

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign req_id[k*T +: T]   = r_id[k];
    assign req_opc[k*2 +: 2]  = r_opc[k];
    assign req_a[k*W +: W]    = r_a[k];
    assign req_b[k*W +: W]    = r_b[k];
  end

  div_arbiter #(.NUM_REQ(N), .WIDTH(W), .TRANS_ID_BITS(T)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_vld_i(req_vld), .req_rdy_o(req_rdy), .req_id_i(req_id), .req_opcode_i(req_opc),
    .req_op_a_i(req_a), .req_op_b_i(req_b),
    .resp_vld_o(resp_vld), .resp_rdy_i(resp_rdy), .resp_id_o(resp_id), .resp_res_o(resp_res),
    .div_in_vld_o(div_in_vld), .div_in_rdy_i(div_in_rdy), .div_id_o(div_id_o),
    .div_opcode_o(div_opc), .div_op_a_o(div_a), .div_op_b_o(div_b), .div_flush_o(div_flush),
    .div_out_vld_i(div_out_vld), .div_out_rdy_o(div_out_rdy), .div_id_i(div_id_in),
    .div_res_i(div_res_in), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension results, including divide-by-zero and signed overflow.
  function automatic logic [63:0] ref_res(input logic [1:0] opc, input logic [63:0] a,
                                          input logic [63:0] b);
    logic signed [63:0] sa, sb;
    sa = a;
    sb = b;
    case (opc)
      2'd0: return (b == 0) ? '1 : a / b;
      2'd1: begin
        if (b == 0) return '1;
        if (a == MIN && sb == -1) return MIN;
        return 64'(sa / sb);
      end
      2'd2: return (b == 0) ? a : a % b;
      default: begin
        if (b == 0) return a;
        if (a == MIN && sb == -1) return 64'd0;
        return 64'(sa % sb);
      end
    endcase
  endfunction

  // Behavioural serial divider: idle -> busy for a latency -> finish until result taken.
  int d_st = 0;
  int d_cnt = 0;
  int d_lat_fix = 0;
  logic [T-1:0] d_id = '0;
  logic [W-1:0] d_res = '0;
  assign div_in_rdy  = (d_st == 0);
  assign div_out_vld = (d_st == 2);
  assign div_id_in   = d_id;
  assign div_res_in  = d_res;

  always @(posedge clk) begin
    if (!rst_n || div_flush) d_st <= 0;
    else case (d_st)
      0: if (div_in_vld) begin
        d_st  <= 1;
        d_cnt <= (d_lat_fix != 0) ? d_lat_fix : int'($urandom_range(1, 6));
        d_id  <= div_id_o;
        d_res <= ref_res(div_opc, div_a, div_b);
      end
      1: if (d_cnt <= 1) d_st <= 2; else d_cnt <= d_cnt - 1;
      default: if (div_out_rdy) d_st <= 0;
    endcase
  end

  // Reference model: one outstanding op at a time, owner, round-robin pointer.
  int rr = 0;
  int m_owner = 0;
  bit m_busy = 0, m_issue = 0, m_byp = 0;
  logic [T-1:0] m_id = '0;
  logic [1:0]   m_opc = '0;
  logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic [N-1:0] took = '0;

  always @(negedge clk) begin : model
    logic [N-1:0] e_rdy, e_resp;
    logic e_in, e_ordy;
    int g, c;
    took = '0;
    if (!rst_n) begin
      rr = 0; m_busy = 0; m_issue = 0; m_byp = 0; m_owner = 0;
    end else begin
      took = req_vld & req_rdy;
      e_rdy = '0; e_resp = '0; e_in = 1'b0; e_ordy = 1'b0; g = -1;
      if (!flush) begin
        e_in = m_issue;
        if (!m_busy && div_in_rdy && (req_vld != 0)) begin
          for (int i = 0; i < N; i++) begin
            c = (rr + i) % N;
            if (g < 0 && req_vld[c]) g = c;
          end
          e_rdy[g] = 1'b1;
        end
        if (m_busy && !m_issue) begin
          if (m_byp || div_out_vld) e_resp[m_owner] = 1'b1;
          if (!m_byp) e_ordy = resp_rdy[m_owner];
        end
      end
      check("div_flush", 64'(div_flush), 64'(flush));
      check("req_rdy", 64'(req_rdy), 64'(e_rdy));
      check("div_in_vld", 64'(div_in_vld), 64'(e_in));
      check("resp_vld", 64'(resp_vld), 64'(e_resp));
      check("div_out_rdy", 64'(div_out_rdy), 64'(e_ordy));
      check("busy", 64'(busy), 64'(m_busy));
      if (e_in) begin
        check("div_id", 64'(div_id_o), 64'(m_id));
        check("div_opc", 64'(div_opc), 64'(m_opc));
        check("div_a", div_a, m_a);
        check("div_b", div_b, m_b);
      end
      if (e_resp != 0) begin
        check("resp_id", 64'(resp_id), 64'(m_id));
        check("resp_res", resp_res, m_res);
      end
      if (flush) begin
        m_busy = 0; m_issue = 0;
      end else if (g >= 0) begin
        m_busy = 1; m_owner = g; rr = (g + 1) % N;
        m_id = r_id[g]; m_opc = r_opc[g]; m_a = r_a[g]; m_b = r_b[g];
        m_res = ref_res(m_opc, m_a, m_b);
        m_byp = BYP && (m_b == 0);
        m_issue = !m_byp;
      end else if (m_issue) begin
        m_issue = 0;
      end else if (m_busy && e_resp[m_owner] && resp_rdy[m_owner]) begin
        m_busy = 0;
      end
    end
  end

  task automatic drive_sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_sync();
    rst_n = 1'b0; req_vld = '0; flush = 1'b0;
    repeat (2) drive_sync();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (busy && t < 200);
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic set_req(input int k, input logic [T-1:0] id, input logic [1:0] opc,
                         input logic [63:0] a, input logic [63:0] b);
    r_id[k] = id; r_opc[k] = opc; r_a[k] = a; r_b[k] = b;
  endtask

  // One request on k, completed with resp_rdy already high; checks against constants.
  task automatic run_one(input int k, input logic [T-1:0] id, input logic [1:0] opc,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp_r);
    int t;
    logic [N-1:0] oh;
    oh = '0;
    oh[k] = 1'b1;
    drive_sync();
    set_req(k, id, opc, a, b);
    req_vld[k] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_rdy[k] && t < 50);
    check("accept", 64'(req_rdy[k]), 64'd1);
    drive_sync();
    req_vld[k] = 1'b0;
    @(negedge clk);
    check("issue_pulse", 64'(div_in_vld), (BYP && b == 0) ? 64'd0 : 64'd1);
    t = 0;
    while (!resp_vld[k] && t < 100) begin @(negedge clk); t++; end
    check("resp_onehot", 64'(resp_vld), 64'(oh));
    check("resp_id_c", 64'(resp_id), 64'(id));
    check("resp_res_c", resp_res, exp_r);
    @(negedge clk);
    check("done_idle", 64'(busy), 64'd0);
  endtask

  task automatic new_req(input int k);
    logic [63:0] b;
    case ($urandom_range(0, 5))
      0: b = 64'd0;
      1: b = '1;
      2: b = 64'($urandom_range(1, 20));
      default: b = {$urandom, $urandom};
    endcase
    set_req(k, T'($urandom), 2'($urandom),
            ($urandom_range(0, 7) == 0) ? MIN : {$urandom, $urandom}, b);
    req_vld[k] = 1'b1;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int t, ng;
    int gl [4];
    for (int k = 0; k < N; k++) set_req(k, '0, '0, '0, '0);

    // Reset with flush high: everything quiet except div_flush following flush.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_rdy", 64'(req_rdy), 64'd0);
    check("rst_resp_vld", 64'(resp_vld), 64'd0);
    check("rst_in_vld", 64'(div_in_vld), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_rdy", 64'(div_out_rdy), 64'd0);
    check("rst_div_a", div_a, 64'd0);
    check("rst_div_id", 64'(div_id_o), 64'd0);
    check("rst_resp_res", resp_res, 64'd0);
    check("rst_flush_thru", 64'(div_flush), 64'd1);
    drive_sync();
    flush = 1'b0;
    @(negedge clk);
    check("rst_flush_low", 64'(div_flush), 64'd0);
    drive_sync();
    rst_n = 1'b1;
    resp_rdy = '1;

    // Single udiv on requester 0.
    run_one(0, 3'd3, 2'd0, 64'd100, 64'd7, 64'd14);

    // Requesters 0 and 1 continuously valid from reset: grants alternate.
    do_reset();
    drive_sync();
    set_req(0, 3'd1, 2'd1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd9);
    set_req(1, 3'd6, 2'd2, 64'd12345, 64'd100);
    req_vld = 3'b011;
    ng = 0; t = 0;
    while (ng < 4 && t < 400) begin
      @(negedge clk); t++;
      if ((req_vld & req_rdy) != 0) begin
        gl[ng] = req_rdy[0] ? 0 : (req_rdy[1] ? 1 : 2);
        ng++;
      end
    end
    drive_sync();
    req_vld = '0;
    check("grant_count", 64'(ng), 64'd4);
    check("grant_seq0", 64'(gl[0]), 64'd0);
    check("grant_seq1", 64'(gl[1]), 64'd1);
    check("grant_seq2", 64'(gl[2]), 64'd0);
    check("grant_seq3", 64'(gl[3]), 64'd1);
    wait_idle();

    // Owner backpressure on rem -7 % 2.
    d_lat_fix = 3;
    drive_sync();
    resp_rdy[0] = 1'b0;
    set_req(0, 3'd2, 2'd3, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    req_vld[0] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_rdy[0] && t < 50);
    drive_sync();
    req_vld[0] = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!resp_vld[0] && t < 50);
    for (int i = 0; i < 5; i++) begin
      check("bp_res", resp_res, '1);
      check("bp_vld", 64'(resp_vld), 64'd1);
      check("bp_out_rdy", 64'(div_out_rdy), 64'd0);
      @(negedge clk);
    end
    drive_sync();
    resp_rdy[0] = 1'b1;
    @(negedge clk);
    check("bp_release", 64'(div_out_rdy), 64'd1);
    @(negedge clk);
    check("bp_busy_clear", 64'(busy), 64'd0);

    // Flush mid-divide of 2^63/3, then a clean op.
    d_lat_fix = 8;
    drive_sync();
    set_req(0, 3'd4, 2'd0, MIN, 64'd3);
    req_vld[0] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_rdy[0] && t < 50);
    drive_sync();
    req_vld[0] = 1'b0;
    repeat (2) drive_sync();
    flush = 1'b1;
    @(negedge clk);
    check("fl_div_flush", 64'(div_flush), 64'd1);
    check("fl_resp_vld", 64'(resp_vld), 64'd0);
    drive_sync();
    flush = 1'b0;
    @(negedge clk);
    check("fl_idle", 64'(busy), 64'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("fl_no_resp", 64'(resp_vld), 64'd0);
    end
    run_one(0, 3'd5, 2'd0, MIN, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA);

    // Flush together with requests in IDLE: no grant, pointer untouched.
    d_lat_fix = 0;
    do_reset();
    drive_sync();
    flush = 1'b1;
    set_req(0, 3'd0, 2'd0, 64'd50, 64'd5);
    set_req(1, 3'd7, 2'd0, 64'd60, 64'd6);
    req_vld = 3'b011;
    @(negedge clk);
    check("flidle_rdy", 64'(req_rdy), 64'd0);
    drive_sync();
    flush = 1'b0;
    @(negedge clk);
    check("flidle_grant", 64'(req_rdy), 64'b001);
    drive_sync();
    req_vld = 3'b000;
    wait_idle();

    // Divide by zero (bypassed locally or sent through the divider).
    run_one(0, 3'd2, 2'd1, 64'd5, 64'd0, '1);
    run_one(0, 3'd4, 2'd3, 64'd5, 64'd0, 64'd5);

    // Random traffic with flushes and one mid-run reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      drive_sync();
      rst_n = !(cyc == 1500 || cyc == 1501);
      for (int k = 0; k < N; k++) begin
        if (took[k]) req_vld[k] = 1'b0;
        if (!req_vld[k] && $urandom_range(0, 3) == 0) new_req(k);
        resp_rdy[k] = ($urandom_range(0, 9) < 7);
      end
      flush = ($urandom_range(0, 49) == 0);
    end
    drive_sync();
    req_vld = '0; flush = 1'b0; resp_rdy = '1; rst_n = 1'b1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
